// File: rtl/mem_port_arbiter_4.sv
// mem_port_arbiter_4
//   Round-robin arbiter for four requesters sharing one memory port. The
//   granted requester's index drives the sel input of the downstream 4:1 data
//   mux. A grant is held until the memory pulses done, the requester drops its
//   request, or the hold counter reaches TIMEOUT cycles.
//
// Parameters
//   TIMEOUT    maximum number of cycles one grant may be held (1..2**CNT_WIDTH-1)
//   CNT_WIDTH  width of the hold-cycle counter
//
// Ports
//   clk      in   1  clock, all state changes on the rising edge
//   rst_n    in   1  asynchronous active-low reset
//   req      in   4  request per requester, bit i = requester i
//   done     in   1  memory transaction complete, 1-cycle pulse while busy
//   gnt      out  4  one-hot grant, all zeros when idle
//   sel      out  2  binary index of the granted requester
//   busy     out  1  high while a grant is held
//   timeout  out  1  1-cycle pulse when a grant is forcibly released
module mem_port_arbiter_4 #(
  parameter int TIMEOUT   = 16,
  parameter int CNT_WIDTH = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state_reg,   state_next;
  logic [1:0]           ptr_reg,     ptr_next;
  logic [CNT_WIDTH-1:0] cnt_reg,     cnt_next;
  logic [3:0]           gnt_reg,     gnt_next;
  logic [1:0]           sel_reg,     sel_next;
  logic                 busy_reg,    busy_next;
  logic                 timeout_reg, timeout_next;

  logic       win_valid;
  logic [1:0] win_idx;
  logic [1:0] cand_idx;
  logic [3:0] win_onehot;
  logic       withdrew;
  logic       at_limit;

  // Round-robin pick: scan ptr, ptr+1, ... (mod 4). The loop runs from the
  // farthest offset down to ptr itself so the nearest set bit is the last
  // assignment and therefore wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = ptr_reg;
    cand_idx  = ptr_reg;
    for (int k = 3; k >= 0; k--) begin
      cand_idx = ptr_reg + 2'(k);
      if (req[cand_idx]) begin
        win_valid = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_onehot
      assign win_onehot[gi] = win_valid && (win_idx == 2'(gi));
    end
  endgenerate

  assign withdrew = !req[sel_reg];
  // cnt counts 0..TIMEOUT-1 over the held cycles, so releasing at TIMEOUT-1
  // gives exactly TIMEOUT cycles of gnt and the counter can never wrap.
  assign at_limit = (cnt_reg == CNT_WIDTH'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ptr_reg     <= 2'd0;
      cnt_reg     <= '0;
      gnt_reg     <= 4'b0000;
      sel_reg     <= 2'd0;
      busy_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      cnt_reg     <= cnt_next;
      gnt_reg     <= gnt_next;
      sel_reg     <= sel_next;
      busy_reg    <= busy_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    cnt_next     = cnt_reg;
    gnt_next     = gnt_reg;
    sel_next     = sel_reg;
    busy_next    = busy_reg;
    timeout_next = 1'b0;

    case (state_reg)
      IDLE: begin
        // done is ignored here; only a pending request starts a grant.
        if (win_valid) begin
          state_next = BUSY;
          gnt_next   = win_onehot;
          sel_next   = win_idx;
          busy_next  = 1'b1;
          cnt_next   = '0;
          // Priority moves on at grant time, so a requester that later times
          // out has already lost its turn.
          ptr_next   = win_idx + 2'd1;
        end
      end

      BUSY: begin
        if (done || withdrew || at_limit) begin
          // sel deliberately keeps its last value across the release.
          state_next   = IDLE;
          gnt_next     = 4'b0000;
          busy_next    = 1'b0;
          cnt_next     = '0;
          timeout_next = !done && !withdrew;
        end else begin
          cnt_next = cnt_reg + CNT_WIDTH'(1);
        end
      end

      default: begin
        state_next = IDLE;
        gnt_next   = 4'b0000;
        busy_next  = 1'b0;
        cnt_next   = '0;
      end
    endcase
  end

  assign gnt     = gnt_reg;
  assign sel     = sel_reg;
  assign busy    = busy_reg;
  assign timeout = timeout_reg;

endmodule

// File: tb/tb_mem_port_arbiter_4.sv
// tb_mem_port_arbiter_4
//   Directed bench for mem_port_arbiter_4 built with TIMEOUT=4. A table of
//   per-cycle vectors (inputs applied at the falling edge, outputs checked
//   just after the next rising edge) covers single grants, round-robin
//   order, skipping, timeout and the release corners; hand-written
//   sequences cover asynchronous reset in the middle of a grant.
module tb_mem_port_arbiter_4;

  localparam int TIMEOUT   = 4;
  localparam int CNT_WIDTH = 5;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int n_checks;
  int n_fail;

  mem_port_arbiter_4 #(
    .TIMEOUT   (TIMEOUT),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] exp_gnt;
    logic [1:0] exp_sel;
    logic       exp_busy;
    logic       exp_to;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic d,
                     input logic [3:0] g, input logic [1:0] s,
                     input logic b, input logic t);
    vec_t v;
    v.rst_n    = r;
    v.req      = rq;
    v.done     = d;
    v.exp_gnt  = g;
    v.exp_sel  = s;
    v.exp_busy = b;
    v.exp_to   = t;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic [1:0] s,
                           input logic b, input logic t);
    $display("%s: req=%b done=%b rst_n=%b -> gnt=%b sel=%0d busy=%b timeout=%b",
             tag, req, done, rst_n, gnt, sel, busy, timeout);
    cmp({tag, " gnt"},     gnt,            g);
    cmp({tag, " sel"},     {2'b00, sel},   {2'b00, s});
    cmp({tag, " busy"},    {3'b000, busy}, {3'b000, b});
    cmp({tag, " timeout"}, {3'b000, timeout}, {3'b000, t});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    req      = 4'b0000;
    done     = 1'b0;

    // Reset asserted between edges must clear outputs without a clock edge.
    #2 rst_n = 1'b0;
    #1 check_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

    //   rst  req      done  gnt      sel   busy  to
    // single grant to requester 2, released by done
    add(1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(1'b1, 4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);
    add(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0);
    // re-reset so round robin starts from requester 0
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    // fairness: all request, done on second held cycle
    add(1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(1'b1, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(1'b1, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(1'b1, 4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0);
    add(1'b1, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(1'b1, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(1'b1, 4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);
    add(1'b1, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    add(1'b1, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    add(1'b1, 4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0);
    add(1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    // skip: serve 1, then 1010 alternates 3,1,3
    add(1'b1, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(1'b1, 4'b0010, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0);
    add(1'b1, 4'b1010, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    add(1'b1, 4'b1010, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0);
    add(1'b1, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(1'b1, 4'b1010, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0);
    add(1'b1, 4'b1010, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    add(1'b1, 4'b1010, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0);
    // timeout: requester 0 holds 4 cycles, then forced release
    add(1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(1'b1, 4'b0011, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1);
    // requester 1 next; timeout pulse lasts one cycle only
    add(1'b1, 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(1'b1, 4'b0011, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0);
    // done coincident with cnt==TIMEOUT-1: done wins, no timeout
    add(1'b1, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(1'b1, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(1'b1, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(1'b1, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(1'b1, 4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    // done while idle does nothing
    add(1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    // withdraw mid-grant: release next edge, no timeout
    add(1'b1, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    add(1'b1, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    add(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0);
    add(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n;
      req   = vecs[i].req;
      done  = vecs[i].done;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].exp_gnt, vecs[i].exp_sel,
                vecs[i].exp_busy, vecs[i].exp_to);
    end

    // Asynchronous reset in the middle of a grant to requester 2.
    @(negedge clk);
    req  = 4'b0100;
    done = 1'b0;
    @(posedge clk);
    #1 check_all("mid_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_all("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0000;

    // Reset on the cycle a timeout would fire: no timeout pulse.
    @(negedge clk);
    req = 4'b0001;
    @(posedge clk);
    #1 check_all("to_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      @(posedge clk);
      #1 check_all($sformatf("to_hold%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    #2 rst_n = 1'b0;
    #1 check_all("to_abort", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 check_all("to_abort_edge", 4'b0000, 2'd0, 1'b0, 1'b0);
    // After reset the pointer is back at 0, so requester 0 wins from 0011.
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0011;
    @(posedge clk);
    #1 check_all("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);
    @(negedge clk);
    done = 1'b1;
    @(posedge clk);
    #1 check_all("post_rst_done", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    done = 1'b0;
    req  = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "time limit");
  end

endmodule
